// File: rtl/tmr_unit.sv
// General-purpose timer: prescaled counter with periodic / one-shot / PWM modes,
// compare match and sticky flags. Define TMR_CAPTURE_EN to add the input-capture channel.
module tmr_unit #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     pr,
    input  logic [PSC_WIDTH-1:0] psc,
    input  logic [WIDTH-1:0]     cmp,
    input  logic                 ovf_ie,
    input  logic                 cmp_ie,
    input  logic                 clr_ovf,
    input  logic                 clr_cmp,
`ifdef TMR_CAPTURE_EN
    input  logic                 cap_in,
    input  logic                 clr_cap,
    output logic [WIDTH-1:0]     cap_val,
    output logic                 cap_flag,
`endif
    output logic [WIDTH-1:0]     tmr,
    output logic                 running,
    output logic                 pwm_out,
    output logic                 ovf_flag,
    output logic                 cmp_flag,
    output logic                 irq
);

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PWM      = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_t;

    // ST_DONE is the one-shot "expired" state; only dropping en leaves it.
    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_DONE   = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     tmr_reg, tmr_next;
    logic [PSC_WIDTH-1:0] psc_cnt_reg, psc_cnt_next;
    logic                 pwm_reg, pwm_next;
    logic                 ovf_reg, ovf_next;
    logic                 cmp_reg, cmp_next;
    logic                 en_d_reg;

    mode_t mode_sel;
    logic  done;
    logic  tick;
    logic  wrap;
    logic  ovf_evt;
    logic  cmp_evt;
    logic  en_rise;

    assign mode_sel = mode_t'(mode);
    assign done     = (state_reg == ST_DONE);
    assign running  = en & ~done;
    // ">=" rather than "==" so lowering psc or pr below the live count still terminates.
    assign tick     = running & (psc_cnt_reg >= psc);
    assign wrap     = (tmr_reg >= pr);
    assign ovf_evt  = tick & wrap;
    assign en_rise  = en & ~en_d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_ACTIVE;
            tmr_reg     <= '0;
            psc_cnt_reg <= '0;
            pwm_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            cmp_reg     <= 1'b0;
            en_d_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmr_reg     <= tmr_next;
            psc_cnt_reg <= psc_cnt_next;
            pwm_reg     <= pwm_next;
            ovf_reg     <= ovf_next;
            cmp_reg     <= cmp_next;
            en_d_reg    <= en;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tmr_next     = tmr_reg;
        psc_cnt_next = '0;
        pwm_next     = 1'b0;
        cmp_evt      = 1'b0;

        if (tick) begin
            tmr_next = wrap ? '0 : tmr_reg + 1'b1;
        end
        if (running && !tick) begin
            psc_cnt_next = psc_cnt_reg + 1'b1;
        end

        cmp_evt  = tick & (tmr_next == cmp);
        pwm_next = (mode_sel == MODE_PWM) & running & (tmr_next < cmp);

        case (state_reg)
            ST_ACTIVE: if (ovf_evt && mode_sel == MODE_ONESHOT) state_next = ST_DONE;
            ST_DONE:   if (en_rise) state_next = ST_ACTIVE;
            default:   state_next = ST_ACTIVE;
        endcase

        if (!en) begin
            state_next   = ST_ACTIVE;
            tmr_next     = '0;
            psc_cnt_next = '0;
            pwm_next     = 1'b0;
        end

        // Flags are sticky and a set beats a simultaneous clear.
        ovf_next = ovf_evt | (ovf_reg & ~clr_ovf);
        cmp_next = cmp_evt | (cmp_reg & ~clr_cmp);
    end

    assign tmr      = tmr_reg;
    assign pwm_out  = pwm_reg;
    assign ovf_flag = ovf_reg;
    assign cmp_flag = cmp_reg;
    assign irq      = (ovf_reg & ovf_ie) | (cmp_reg & cmp_ie);

`ifdef TMR_CAPTURE_EN
    // Two synchroniser flops followed by the edge-history flop.
    logic [2:0]       cap_sync_reg;
    logic             cap_rise;
    logic [WIDTH-1:0] cap_val_reg;
    logic             cap_flag_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cap_sync_reg[0] <= 1'b0;
        else      cap_sync_reg[0] <= cap_in;
    end

    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_cap_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) cap_sync_reg[gi] <= 1'b0;
                else      cap_sync_reg[gi] <= cap_sync_reg[gi-1];
            end
        end
    endgenerate

    assign cap_rise = cap_sync_reg[1] & ~cap_sync_reg[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_val_reg  <= '0;
            cap_flag_reg <= 1'b0;
        end else begin
            if (cap_rise) cap_val_reg <= tmr_reg;
            cap_flag_reg <= cap_rise | (cap_flag_reg & ~clr_cap);
        end
    end

    assign cap_val  = cap_val_reg;
    assign cap_flag = cap_flag_reg;
`endif

endmodule

// File: tb/tb_tmr_unit.sv
// Self-checking bench for tmr_unit: directed scenarios plus randomized stimulus
// compared against a cycle-level behavioural model of the timer rules.
module tb_tmr_unit;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  pr = '0;
    logic [PW-1:0] psc = '0;
    logic [W-1:0]  cmp = '0;
    logic          ovf_ie = 1'b0;
    logic          cmp_ie = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          clr_cmp = 1'b0;
    logic [W-1:0]  tmr;
    logic          running;
    logic          pwm_out;
    logic          ovf_flag;
    logic          cmp_flag;
    logic          irq;
`ifdef TMR_CAPTURE_EN
    logic          cap_in = 1'b0;
    logic          clr_cap = 1'b0;
    logic [W-1:0]  cap_val;
    logic          cap_flag;
`endif

    tmr_unit #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .pr       (pr),
        .psc      (psc),
        .cmp      (cmp),
        .ovf_ie   (ovf_ie),
        .cmp_ie   (cmp_ie),
        .clr_ovf  (clr_ovf),
        .clr_cmp  (clr_cmp),
`ifdef TMR_CAPTURE_EN
        .cap_in   (cap_in),
        .clr_cap  (clr_cap),
        .cap_val  (cap_val),
        .cap_flag (cap_flag),
`endif
        .tmr      (tmr),
        .running  (running),
        .pwm_out  (pwm_out),
        .ovf_flag (ovf_flag),
        .cmp_flag (cmp_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_tmr;
    int m_psc;
    bit m_done;
    bit m_pwm;
    bit m_ovf;
    bit m_cmpf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tmr  = 0;
        m_psc  = 0;
        m_done = 1'b0;
        m_pwm  = 1'b0;
        m_ovf  = 1'b0;
        m_cmpf = 1'b0;
    endtask

    // Apply one clock edge's worth of timer rules to the model using current inputs.
    task automatic model_step();
        bit run;
        bit tk;
        bit ovf;
        int nt;
        run = en && !m_done;
        tk  = run && (m_psc >= int'(psc));
        nt  = m_tmr;
        ovf = 1'b0;
        if (tk) begin
            if (m_tmr >= int'(pr)) begin
                nt  = 0;
                ovf = 1'b1;
            end else begin
                nt = m_tmr + 1;
            end
        end
        m_ovf  = ovf || (m_ovf && !clr_ovf);
        m_cmpf = (tk && nt == int'(cmp)) || (m_cmpf && !clr_cmp);
        if (!en) begin
            m_tmr  = 0;
            m_psc  = 0;
            m_done = 1'b0;
            m_pwm  = 1'b0;
        end else begin
            m_pwm = (mode == 2'b10) && run && (nt < int'(cmp));
            m_psc = tk ? 0 : (run ? m_psc + 1 : 0);
            if (ovf && mode == 2'b01) m_done = 1'b1;
            m_tmr = nt;
        end
    endtask

    task automatic compare_all();
        bit exp_irq;
        exp_irq = (m_ovf && ovf_ie) || (m_cmpf && cmp_ie);
        check("tmr",      32'(tmr),      32'(m_tmr));
        check("running",  32'(running),  32'(en && !m_done));
        check("pwm_out",  32'(pwm_out),  32'(m_pwm));
        check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
        check("cmp_flag", 32'(cmp_flag), 32'(m_cmpf));
        check("irq",      32'(irq),      32'(exp_irq));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_tmr(input int v, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            cycle();
            if (tmr == W'(v)) hit = 1'b1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        int cnt;
        int k;
        bit seen_nz;

        // Reset held from time 0
        #12;
        check("rst_tmr",  32'(tmr),      32'd0);
        check("rst_run",  32'(running),  32'd0);
        check("rst_pwm",  32'(pwm_out),  32'd0);
        check("rst_ovf",  32'(ovf_flag), 32'd0);
        check("rst_cmpf", 32'(cmp_flag), 32'd0);
        check("rst_irq",  32'(irq),      32'd0);
        $display("reset: tmr=%0d running=%0d irq=%0d", tmr, running, irq);
        model_reset();

        // Basic periodic count 0..4
        rst = 1'b1; en = 1'b1; mode = 2'b00; psc = '0; pr = W'(4); ovf_ie = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            check("basic_seq", 32'(tmr), 32'(i % 5));
            check("basic_ovf", 32'(ovf_flag), 32'(i >= 5));
            check("basic_irq", 32'(irq), 32'(i >= 5));
        end
        $display("basic: tmr=%0d ovf_flag=%0d irq=%0d", tmr, ovf_flag, irq);

        // Prescaler: first wrap 12 clocks after counting starts
        en = 1'b0; clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        psc = PW'(2); pr = W'(3); en = 1'b1;
        seen_nz = 1'b0;
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            cycle();
            if (tmr != '0) seen_nz = 1'b1;
            else if (seen_nz) k = i;
        end
        check("psc_wrap_clk", 32'(k), 32'd12);
        $display("prescaler: first wrap after %0d clk", k);

        // One-shot
        en = 1'b0; mode = 2'b01; pr = W'(5); psc = '0; clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (int'(tmr) > cnt) cnt = int'(tmr);
        end
        check("os_max",  32'(cnt),      32'd5);
        check("os_tmr",  32'(tmr),      32'd0);
        check("os_run",  32'(running),  32'd0);
        check("os_ovf",  32'(ovf_flag), 32'd1);
        en = 1'b0; cycle(); en = 1'b1; cycle();
        check("os_restart", 32'(tmr), 32'd1);
        $display("one-shot: max=%0d restart tmr=%0d", cnt, tmr);

        // PWM duty cycles
        en = 1'b0; cycle();
        mode = 2'b10; pr = W'(9); cmp = W'(3); en = 1'b1;
        repeat (10) cycle();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(pwm_out); end
        check("pwm_duty3", 32'(cnt), 32'd3);
        $display("pwm: cmp=3 high=%0d/10", cnt);
        cmp = W'(0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(pwm_out); end
        check("pwm_cmp0", 32'(cnt), 32'd0);
        $display("pwm: cmp=0 high=%0d/10", cnt);
        cmp = W'(12);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(pwm_out); end
        check("pwm_cmp12", 32'(cnt), 32'd10);
        $display("pwm: cmp=12 high=%0d/10", cnt);

        // Compare flag, set-beats-clear, plain clear
        en = 1'b0; mode = 2'b00; pr = W'(7); cmp = W'(2); psc = '0;
        ovf_ie = 1'b0; cmp_ie = 1'b1; clr_cmp = 1'b1; clr_ovf = 1'b1;
        cycle();
        clr_cmp = 1'b0; clr_ovf = 1'b0; en = 1'b1;
        check("cmp_clear0", 32'(cmp_flag), 32'd0);
        wait_tmr(2, 20, "wait_tmr2");
        check("cmp_hit",  32'(cmp_flag), 32'd1);
        check("cmp_irq",  32'(irq),      32'd1);
        wait_tmr(1, 20, "wait_tmr1");
        clr_cmp = 1'b1; cycle(); clr_cmp = 1'b0;
        check("cmp_setwins", 32'(cmp_flag), 32'd1);
        clr_cmp = 1'b1; cycle(); clr_cmp = 1'b0;
        check("cmp_cleared", 32'(cmp_flag), 32'd0);
        check("cmp_irq_off", 32'(irq),      32'd0);
        $display("flags: cmp_flag=%0d irq=%0d", cmp_flag, irq);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) en = ~en;
            if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) pr = W'($urandom_range(12));
            if ($urandom_range(15) == 0) psc = PW'($urandom_range(3));
            if ($urandom_range(15) == 0) cmp = W'($urandom_range(14));
            if ($urandom_range(9) == 0) ovf_ie = ~ovf_ie;
            if ($urandom_range(9) == 0) cmp_ie = ~cmp_ie;
            clr_ovf = ($urandom_range(7) == 0);
            clr_cmp = ($urandom_range(7) == 0);
            cycle();
        end
        clr_ovf = 1'b0; clr_cmp = 1'b0;
        $display("random: 3000 cycles, %0d mismatched so far", n_bad);

        // Asynchronous reset between clock edges
        en = 1'b0; mode = 2'b10; psc = '0; pr = W'(9); cmp = W'(7); cycle();
        en = 1'b1;
        wait_tmr(6, 20, "wait_tmr6");
        check("pre_rst_pwm", 32'(pwm_out), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("arst_tmr",  32'(tmr),      32'd0);
        check("arst_pwm",  32'(pwm_out),  32'd0);
        check("arst_ovf",  32'(ovf_flag), 32'd0);
        check("arst_cmpf", 32'(cmp_flag), 32'd0);
        model_reset();
        #1 rst = 1'b1;
        cycle();
        check("arst_resume", 32'(tmr), 32'd1);
        cycle();
        $display("async reset: resumed tmr=%0d", tmr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmr_unit.md
Name: tmr_unit

Overview:
- Parametrised successor to the single-channel 16-bit free-running timer counter.
- Adds:
  - programmable prescaler
  - periodic / one-shot / PWM modes
  - compare match
  - sticky overflow and compare flags with interrupt enables
- Sits on the SoC peripheral bus as the general-purpose timer. The register-interface wrapper drives its control inputs and reads tmr and the flags.

Parameters:
- WIDTH, 16, counter, period and compare width in bits.
- PSC_WIDTH, 8, prescaler divide-value width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- en  input  1  timer enable. Low forces counters to zero.
- mode  input  2  00 periodic, 01 one-shot, 10 PWM, 11 reserved (behaves as periodic).
- pr  input  WIDTH  period. Count runs 0..pr inclusive.
- psc  input  PSC_WIDTH  prescaler. One count tick every psc+1 clk cycles.
- cmp  input  WIDTH  compare value.
- ovf_ie  input  1  overflow interrupt enable.
- cmp_ie  input  1  compare interrupt enable.
- clr_ovf  input  1  single-cycle pulse, clears ovf_flag.
- clr_cmp  input  1  single-cycle pulse, clears cmp_flag.
- tmr  output  WIDTH  current count.
- running  output  1  high while the counter is advancing.
- pwm_out  output  1  PWM waveform (mode 10 only).
- ovf_flag  output  1  sticky period-end flag.
- cmp_flag  output  1  sticky compare-match flag.
- irq  output  1  (ovf_flag & ovf_ie) | (cmp_flag & cmp_ie). Combinational from registers.

Behaviour:
- Reset (rst=0): tmr=0, psc_cnt=0, done=0, pwm_out=0, ovf_flag=0, cmp_flag=0, en_d=0. Therefore running=0 and irq=0.
- running = en & ~done.
- Prescaler:
  - psc_cnt counts 0..psc while running.
  - tick=1 in a cycle where running and psc_cnt>=psc; psc_cnt then returns to 0.
  - psc=0 gives a tick every cycle.
  - psc lowered below psc_cnt: next cycle ticks (>= compare).
- Count on tick:
  - tmr>=pr: tmr<=0 and an overflow event fires.
  - otherwise: tmr<=tmr+1.
  - pr=0: tmr stays 0, overflow every tick.
  - pr lowered below the current tmr: wrap on the next tick.
- Counter never exceeds 2^WIDTH-1. Wrap is governed only by the >=pr compare.
- Between ticks, tmr holds its value.
- en=0 (synchronous):
  - tmr<=0, psc_cnt<=0, done<=0, pwm_out<=0.
  - Flags hold their values.
- Mode 01 (one-shot):
  - An overflow event sets done.
  - done blocks ticks (tmr stays 0) until en is deasserted.
  - en_d registers en. A rising edge of en (en & ~en_d) restarts the count from 0.
- Mode 10 (PWM):
  - pwm_out is registered: pwm_out <= running & (next_tmr < cmp).
  - cmp=0: pwm_out constant 0.
  - cmp>pr: pwm_out constant 1 while running.
  - Other modes: pwm_out=0.
- Compare match:
  - cmp_flag sets on the edge where tmr is loaded with a value equal to cmp, on a tick only.
  - cmp=0 therefore matches at each wrap.
- ovf_flag sets on every overflow event (all modes).
- Flag set and clear in the same cycle: set wins, flag stays 1.
- mode change while running: takes effect on the next tick. tmr and psc_cnt are not reset.
- Reset asserted mid-count: all state clears immediately. Counting resumes from 0 after release if en=1.

Optional Feature:
- Macro TMR_CAPTURE_EN.
- Defined:
  - Adds ports cap_in (input 1), cap_val (output WIDTH), cap_flag (output 1), clr_cap (input 1).
  - cap_in passes through a 2-flop synchroniser plus an edge register.
  - A synchronised rising edge latches tmr into cap_val and sets cap_flag. Capture latency is 3 clk cycles from cap_in rising.
  - Capture edge and clr_cap in the same cycle: set wins.
  - cap_val and cap_flag reset to 0.
  - cap_flag is not ORed into irq.
- Undefined: ports, synchroniser and capture logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset/basic: rst=0 then 1, en=1, mode=00, psc=0, pr=4 -> tmr 0,1,2,3,4,0,1..., ovf_flag sets on the 0 after 4. With ovf_ie=1, irq=1 from that edge.
- Prescaler: psc=2, pr=3 -> tmr increments every 3 clk. First wrap to 0 occurs 12 clk after counting starts.
- One-shot: mode=01, pr=5 -> tmr counts 0..5 then sticks at 0, running=0, ovf_flag=1. en 1->0->1 restarts the count from 0.
- PWM: mode=10, psc=0, pr=9, cmp=3 -> pwm_out high 3 of every 10 clk. cmp=0 -> pwm_out stays 0. cmp=12 -> pwm_out stays 1.
- Flags: cmp=2, pr=7, cmp_ie=1 -> cmp_flag/irq assert when tmr reaches 2. Pulsing clr_cmp in the same cycle as the next match leaves cmp_flag=1. clr_cmp on a non-match cycle clears it.
- Async reset mid-run: tmr=6, rst pulled low between clk edges -> tmr, flags, pwm_out read 0 before the next clk edge.
